// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns,
// special result codes and the reader state encoding.
package seven_seg_pkg;

  // Active-high segment patterns (bit0=a .. bit6=g) for digits 0..9.
  // The display decoder uses the same table, so both ends stay identical.
  // Element d of the packed array is the pattern for digit d.
  localparam logic [9:0][6:0] SEG_PATTERNS = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    CAPTURED = 2'd2
  } state_e;

endpackage

// File: rtl/segment_pattern_to_bcd.sv
// Inverse 7-segment decoder: active-low pattern in, digit code out.
// Blank (all segments off) and unrecognised patterns get special codes.
module segment_pattern_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern_n,
  output logic [3:0] code,
  output logic       legal,
  output logic       blank
);

  logic [6:0] lit;

  // Compare the lit segments against every digit pattern in the table
  always_comb begin
    lit   = ~pattern_n;
    code  = ERR_CODE;
    legal = 1'b0;
    blank = 1'b0;
    if (lit == 7'b0000000) begin
      code  = BLANK_CODE;
      blank = 1'b1;
    end else begin
      for (int d = 0; d < 10; d++) begin
        if (lit == SEG_PATTERNS[d]) begin
          code  = 4'(d);
          legal = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed active-low 7-segment bus: synchronises the lines,
// waits for a stable one-hot digit enable, decodes the segments and
// keeps the last result per digit position.
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_error,
  output logic                    update,
  output logic                    frame_valid
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [SW-1:0]           sync1_q, sync1_d;
  logic [SW-1:0]           sync2_q, sync2_d;
  logic [SW-1:0]           prev_q, prev_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   error_q, error_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    update_q, update_d;
  logic                    frame_q, frame_d;

  logic [NUM_DIGITS-1:0]   sel;
  logic                    changed;
  logic                    one_hot;
  logic                    capture;
  logic [3:0]              dec_code;
  logic                    dec_legal;
  logic                    dec_blank;

  segment_pattern_to_bcd u_decode (
    .pattern_n (sync2_q[6:0]),
    .code      (dec_code),
    .legal     (dec_legal),
    .blank     (dec_blank)
  );

  // Next-state logic: sync pipeline, stability count, FSM and capture
  always_comb begin
    sync1_d  = {digit_en, segments};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    sel      = ~sync2_q[SW-1:7];
    changed  = (sync2_q != prev_q);
    one_hot  = $onehot(sel);
    capture  = 1'b0;
    state_d  = state_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    error_d  = error_q;

    if (changed)                 cnt_d = '0;
    else if (cnt_q == STABLE_MAX) cnt_d = cnt_q;
    else                         cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (one_hot) state_d = SETTLING;
      end
      SETTLING: begin
        if (!one_hot) begin
          state_d = IDLE;
        end else if (!changed && cnt_q >= STABLE_PRE) begin
          // Counter reaches STABLE_CYCLES on this edge
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (changed) state_d = one_hot ? SETTLING : IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && sel[i]) begin
        digits_d[4*i +: 4] = dec_code;
        valid_d[i]         = dec_legal;
        error_d[i]         = !dec_legal && !dec_blank;
      end
    end

    seen_d   = seen_q | (capture ? sel : '0);
    update_d = capture;
    frame_d  = frame_q | (&seen_d);
  end

  // All state and registered outputs; reset returns the bus to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      prev_q   <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      digits_q <= {NUM_DIGITS{BLANK_CODE}};
      valid_q  <= '0;
      error_q  <= '0;
      seen_q   <= '0;
      update_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      seen_q   <= seen_d;
      update_q <= update_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_error = error_q;
  assign update      = update_q;
  assign frame_valid = frame_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: the stimulus pushes the
// expected result of each capture, a monitor pops on every update pulse.
module tb_seven_segment_reader;

  logic        clk;
  logic        rst_n;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_error;
  logic        update;
  logic        frame_valid;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
    logic        fv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  seven_segment_reader #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .segments    (segments),
    .digit_en    (digit_en),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_error (digit_error),
    .update      (update),
    .frame_valid (frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] v, input logic [3:0] e, input logic fv);
    exp_t x;
    x.d = d; x.v = v; x.e = e; x.fv = fv;
    exp_q.push_back(x);
  endtask

  // Drive active-high lit segments onto the active-low bus and hold
  task automatic drive(input logic [3:0] en, input logic [6:0] lit, input int hold);
    digit_en = en;
    segments = ~lit;
    repeat (hold) @(negedge clk);
  endtask

  // Drive and hold, measuring when the update pulse appears and how often
  task automatic measure(input logic [3:0] en, input logic [6:0] lit, input int hold,
                         input int exp_lat, input string tag);
    int first;
    int n;
    first = 0;
    n = 0;
    digit_en = en;
    segments = ~lit;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (update) begin
        n++;
        if (first == 0) first = c;
      end
    end
    chk({tag, "_latency"}, first, exp_lat);
    chk({tag, "_pulses"}, n, 1);
  endtask

  // Monitor: one scoreboard entry per update pulse
  always @(negedge clk) begin
    if (rst_n && update) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update actual=%h required=none", digits);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("cap_digits", digits, x.d);
        chk("cap_valid", digit_valid, x.v);
        chk("cap_error", digit_error, x.e);
        chk("cap_frame", frame_valid, x.fv);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    digit_en = 4'b1111;
    segments = 7'h7F;
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 16'hFFFF);
    chk("rst_valid", digit_valid, 4'b0000);
    chk("rst_error", digit_error, 4'b0000);
    chk("rst_update", update, 1'b0);
    chk("rst_frame", frame_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Digit 2 on position 0: single capture 11 edges after the change
    push(16'hFFF2, 4'b0001, 4'b0000, 1'b0);
    measure(4'b1110, 7'b1011011, 20, 11, "first");

    // Scan 7,3,9,0 across positions 0..3
    push(16'hFFF7, 4'b0001, 4'b0000, 1'b0);
    drive(4'b1110, 7'b0000111, 12);
    push(16'hFF37, 4'b0011, 4'b0000, 1'b0);
    drive(4'b1101, 7'b1001111, 12);
    push(16'hF937, 4'b0111, 4'b0000, 1'b0);
    drive(4'b1011, 7'b1101111, 12);
    push(16'h0937, 4'b1111, 4'b0000, 1'b1);
    drive(4'b0111, 7'b0111111, 12);

    // Position 1: 8 held 10 cycles (long enough to capture), a 5-cycle
    // glitch showing 1 that must not capture, then 8 again
    push(16'h0987, 4'b1111, 4'b0000, 1'b1);
    drive(4'b1101, 7'b1111111, 10);
    drive(4'b1101, 7'b0000110, 5);
    push(16'h0987, 4'b1111, 4'b0000, 1'b1);
    drive(4'b1101, 7'b1111111, 12);

    // Two anodes low, then none low: never captures
    drive(4'b1100, 7'b1011011, 30);
    drive(4'b1111, 7'b0000000, 20);

    // Illegal pattern on position 2, then blank clears the error
    push(16'h0E87, 4'b1011, 4'b0100, 1'b1);
    drive(4'b1011, 7'b1000000, 12);
    push(16'h0F87, 4'b1011, 4'b0000, 1'b1);
    drive(4'b1011, 7'b0000000, 12);

    // Reset one cycle before a capture would land
    drive(4'b1110, 7'b1100110, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_digits", digits, 16'hFFFF);
    chk("arst_valid", digit_valid, 4'b0000);
    chk("arst_error", digit_error, 4'b0000);
    chk("arst_update", update, 1'b0);
    chk("arst_frame", frame_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("arst_no_pulse", update, 1'b0);
    rst_n = 1'b1;
    push(16'hFFF4, 4'b0001, 4'b0000, 1'b0);
    measure(4'b1110, 7'b1100110, 14, 11, "post_rst");

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
